// File: rtl/matrix_input_packer.sv
// -----------------------------------------------------------------------------
// matrix_input_packer
//
// Write-side front end for the matrix storage block. Collects a row-major
// stream of DATAWIDTH-bit elements for a matrix of 1..MAXDIM x 1..MAXDIM,
// packs element idx = (r-1)*col + (c-1) into data_flow[DATAWIDTH*idx +: DATAWIDTH]
// (no padding to a MAXDIM-wide stride), then issues one single-cycle write_en
// and holds data_flow / mat_row / mat_col stable for two further cycles so the
// storage, which captures two cycles after the strobe edge, sees settled data.
//
// Handshake: an element transfers on any rising edge where
// elem_valid & elem_ready are both high; elem_ready is high only in LOAD,
// and elem_valid is ignored everywhere else.
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   start                begin a matrix (sampled only in IDLE)
//   cfg_row, cfg_col     requested dimensions, legal 1..MAXDIM
//   abort                drop the matrix being loaded (LOAD only)
//   elem_valid/elem_data element stream in
//   elem_ready           element accepted when elem_valid & elem_ready
//   write_en             storage write strobe, single-cycle pulse
//   mat_row, mat_col     latched dimensions
//   data_flow            packed matrix word
//   busy                 high in any non-IDLE state
//   done                 one-cycle pulse after a completed write
//   err_dim              one-cycle pulse on start with illegal dimensions
//   dbg_state            current FSM state, for observation only
// -----------------------------------------------------------------------------
module matrix_input_packer #(
  parameter int DATAWIDTH = 8,
  parameter int MAXDIM    = 5,
  parameter int FLOWWIDTH = MAXDIM * MAXDIM * DATAWIDTH
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [2:0]           cfg_row,
  input  logic [2:0]           cfg_col,
  input  logic                 abort,
  input  logic                 elem_valid,
  input  logic [DATAWIDTH-1:0] elem_data,
  output logic                 elem_ready,
  output logic                 write_en,
  output logic [2:0]           mat_row,
  output logic [2:0]           mat_col,
  output logic [FLOWWIDTH-1:0] data_flow,
  output logic                 busy,
  output logic                 done,
  output logic                 err_dim,
  output logic [2:0]           dbg_state
);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_LOAD  = 3'd1;
  localparam logic [2:0] ST_WRITE = 3'd2;
  localparam logic [2:0] ST_HOLD1 = 3'd3;
  localparam logic [2:0] ST_HOLD2 = 3'd4;

  localparam logic [2:0] MAX_DIM3 = 3'(MAXDIM);

  logic [2:0] state;
  logic [4:0] idx;    // next element slot
  logic [4:0] total;  // row*col, at most 25

  logic dims_ok;
  assign dims_ok = (cfg_row != 3'd0) && (cfg_row <= MAX_DIM3) &&
                   (cfg_col != 3'd0) && (cfg_col <= MAX_DIM3);

  assign dbg_state = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      idx        <= 5'd0;
      total      <= 5'd0;
      elem_ready <= 1'b0;
      write_en   <= 1'b0;
      mat_row    <= 3'd0;
      mat_col    <= 3'd0;
      data_flow  <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err_dim    <= 1'b0;
    end else begin
      // Pulse outputs default low; the branches below raise them for one cycle.
      write_en <= 1'b0;
      done     <= 1'b0;
      err_dim  <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (start) begin
            if (dims_ok) begin
              mat_row    <= cfg_row;
              mat_col    <= cfg_col;
              total      <= {2'b00, cfg_row} * {2'b00, cfg_col};
              data_flow  <= '0;
              idx        <= 5'd0;
              state      <= ST_LOAD;
              busy       <= 1'b1;
              elem_ready <= 1'b1;
            end else begin
              // Previous matrix outputs are left untouched on a bad request.
              err_dim <= 1'b1;
            end
          end
        end

        ST_LOAD: begin
          if (abort) begin
            // Abort wins over a simultaneous handshake; partial data stays.
            state      <= ST_IDLE;
            busy       <= 1'b0;
            elem_ready <= 1'b0;
          end else if (elem_valid) begin
            data_flow[idx*DATAWIDTH +: DATAWIDTH] <= elem_data;
            idx <= idx + 5'd1;
            if (idx == total - 5'd1) begin
              state      <= ST_WRITE;
              elem_ready <= 1'b0;
              write_en   <= 1'b1;
            end
          end
        end

        ST_WRITE: state <= ST_HOLD1;

        ST_HOLD1: state <= ST_HOLD2;

        ST_HOLD2: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
          done  <= 1'b1;
        end

        default: begin
          state      <= ST_IDLE;
          busy       <= 1'b0;
          elem_ready <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_matrix_input_packer.sv
// -----------------------------------------------------------------------------
// tb_matrix_input_packer
//
// Directed sequence plus randomized matrices. Expected packed words come from a
// byte queue (row-major element list) laid out at 8*i; pulse counts are
// tallied by a negedge monitor.
// -----------------------------------------------------------------------------
module tb_matrix_input_packer;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [2:0]   cfg_row;
  logic [2:0]   cfg_col;
  logic         abort;
  logic         elem_valid;
  logic [7:0]   elem_data;
  logic         elem_ready;
  logic         write_en;
  logic [2:0]   mat_row;
  logic [2:0]   mat_col;
  logic [199:0] data_flow;
  logic         busy;
  logic         done;
  logic         err_dim;
  logic [2:0]   dbg_state;

  matrix_input_packer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .cfg_row    (cfg_row),
    .cfg_col    (cfg_col),
    .abort      (abort),
    .elem_valid (elem_valid),
    .elem_data  (elem_data),
    .elem_ready (elem_ready),
    .write_en   (write_en),
    .mat_row    (mat_row),
    .mat_col    (mat_col),
    .data_flow  (data_flow),
    .busy       (busy),
    .done       (done),
    .err_dim    (err_dim),
    .dbg_state  (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- pulse monitor ----------------
  int wr_cnt   = 0;
  int done_cnt = 0;
  always @(negedge clk) begin
    if (write_en === 1'b1) wr_cnt++;
    if (done === 1'b1)     done_cnt++;
  end

  // ---------------- scoreboard / model ----------------
  logic [7:0] exp_q[$];      // row-major element list of the current matrix
  logic [199:0] exp_flow = '0;
  logic [2:0]   exp_row  = 3'd0;
  logic [2:0]   exp_col  = 3'd0;

  int n_pass  = 0;
  int n_fail  = 0;
  int n_total = 0;

  function automatic logic [199:0] pack_q();
    logic [199:0] w;
    w = '0;
    foreach (exp_q[i]) w[8*i +: 8] = exp_q[i];
    return w;
  endfunction

  task automatic check(input string tag, input logic [199:0] obs, input logic [199:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // All driving and sampling happens 1 time unit after a falling edge.
  task automatic step();
    @(negedge clk);
    #1;
  endtask

  // ---------------- driver tasks ----------------
  // mode 0: valid always high, 1: valid every other cycle, 2: random valid.
  // pattern >= 0: elements pattern, pattern+1, ...; otherwise random bytes.
  task automatic run_matrix(input int r, input int c, input int mode,
                            input int pattern, input bit extra_start);
    int n, k, cyc, wr0, done0;
    bit v;
    n = r * c;
    exp_q.delete();
    for (int i = 0; i < n; i++)
      exp_q.push_back(pattern >= 0 ? 8'(pattern + i) : 8'($urandom_range(0, 255)));
    wr0 = wr_cnt;
    done0 = done_cnt;

    start = 1'b1; cfg_row = 3'(r); cfg_col = 3'(c);
    step();
    start = 1'b0;
    check("start_busy_ready", 200'({busy, elem_ready}), 200'(2'b11));
    check("start_dims", 200'({mat_row, mat_col}), 200'({3'(r), 3'(c)}));
    check("start_clear", data_flow, 200'd0);

    k = 0;
    cyc = 0;
    while (k < n && cyc < 400) begin
      v = (mode == 0) ? 1'b1 : (mode == 1) ? (cyc % 2 == 0) : 1'($urandom_range(0, 1));
      elem_valid = v;
      elem_data  = v ? exp_q[k] : 8'($urandom_range(0, 255));
      if (extra_start) begin
        start = 1'($urandom_range(0, 1)); cfg_row = 3'd1; cfg_col = 3'd1;
      end
      check("load_ready_wr_busy", 200'({elem_ready, write_en, busy}), 200'(3'b101));
      step();
      cyc++;
      if (v) k++;
    end
    elem_valid = 1'b0;
    start = 1'b0;
    if (k != n) check("load_timeout", 200'(k), 200'(n));

    exp_flow = pack_q();
    exp_row = 3'(r);
    exp_col = 3'(c);
    check("write_pulse", 200'({write_en, elem_ready, busy}), 200'(3'b101));
    check("write_data", data_flow, exp_flow);

    step();  // HOLD1
    if (extra_start) begin
      start = 1'b1; cfg_row = 3'd1; cfg_col = 3'd1;
    end
    check("hold1_ctl", 200'({write_en, busy, done}), 200'(3'b010));
    check("hold1_data", data_flow, exp_flow);

    step();  // HOLD2
    start = 1'b0;
    check("hold2_ctl", 200'({write_en, busy, done}), 200'(3'b010));
    check("hold2_dims", 200'({mat_row, mat_col}), 200'({exp_row, exp_col}));
    check("hold2_data", data_flow, exp_flow);

    step();  // first IDLE cycle
    check("done_pulse", 200'({done, busy, elem_ready, write_en}), 200'(4'b1000));
    step();
    check("done_clear", 200'(done), 200'd0);
    check("idle_data_kept", data_flow, exp_flow);
    check("one_write", 200'(wr_cnt - wr0), 200'd1);
    check("one_done", 200'(done_cnt - done0), 200'd1);
  endtask

  task automatic bad_start(input int r, input int c);
    int wr0;
    wr0 = wr_cnt;
    start = 1'b1; cfg_row = 3'(r); cfg_col = 3'(c);
    step();
    start = 1'b0;
    check("err_dim_pulse", 200'({err_dim, busy, elem_ready}), 200'(3'b100));
    check("err_dims_kept", 200'({mat_row, mat_col}), 200'({exp_row, exp_col}));
    check("err_data_kept", data_flow, exp_flow);
    step();
    check("err_dim_clear", 200'({err_dim, busy}), 200'd0);
    check("err_no_write", 200'(wr_cnt - wr0), 200'd0);
  endtask

  // Loads nel elements back-to-back, then aborts (optionally with a
  // simultaneous element offered, which must be dropped).
  task automatic abort_matrix(input int r, input int c, input int nel, input bit valid_on_abort);
    int wr0, done0;
    wr0 = wr_cnt;
    done0 = done_cnt;
    exp_q.delete();
    start = 1'b1; cfg_row = 3'(r); cfg_col = 3'(c);
    step();
    start = 1'b0;
    for (int i = 0; i < nel; i++) begin
      exp_q.push_back(8'($urandom_range(1, 255)));
      elem_valid = 1'b1;
      elem_data  = exp_q[i];
      step();
    end
    abort = 1'b1;
    elem_valid = valid_on_abort;
    elem_data = 8'($urandom_range(1, 255));
    check("abort_in_load", 200'({busy, elem_ready}), 200'(2'b11));
    step();
    abort = 1'b0;
    elem_valid = 1'b0;
    exp_flow = pack_q();
    exp_row = 3'(r);
    exp_col = 3'(c);
    check("abort_idle", 200'({busy, elem_ready, write_en}), 200'd0);
    check("abort_partial", data_flow, exp_flow);
    repeat (5) step();
    check("abort_no_write", 200'(wr_cnt - wr0), 200'd0);
    check("abort_no_done", 200'(done_cnt - done0), 200'd0);
  endtask

  task automatic check_all_zero(input string tag);
    check(tag, {data_flow[193:0], mat_row, mat_col},  200'd0);
    check({tag, "_ctl"}, 200'({elem_ready, write_en, busy, done, err_dim}), 200'd0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int wr0, done0;
    rst_n = 1'b0; start = 1'b0; cfg_row = 3'd0; cfg_col = 3'd0;
    abort = 1'b0; elem_valid = 1'b0; elem_data = 8'd0;
    repeat (2) step();
    check_all_zero("reset");
    rst_n = 1'b1;
    step();

    // 2x3, 0x11..0x16 back-to-back
    run_matrix(2, 3, 0, 8'h11, 1'b0);
    check("r2c3_low48", 200'(data_flow[47:0]), 200'(48'h161514131211));
    check("r2c3_upper", 200'(data_flow[199:48]), 200'd0);

    // 5x5, 1..25, valid toggled every other cycle
    run_matrix(5, 5, 1, 1, 1'b0);
    check("r5c5_top", 200'(data_flow[199:192]), 200'd25);
    check("r5c5_bot", 200'(data_flow[7:0]), 200'd1);

    // illegal dimensions
    bad_start(0, 3);
    bad_start(6, 1);
    bad_start(2, 0);
    bad_start(7, 7);

    // 1x1, 0xAB
    run_matrix(1, 1, 0, 8'hAB, 1'b0);
    check("r1c1_word", data_flow, 200'h0AB);

    // abort after 4 of 9, then a clean 1x2
    abort_matrix(3, 3, 4, 1'b1);
    run_matrix(1, 2, 0, -1, 1'b0);
    check("r1c2_upper_zero", 200'(data_flow[199:16]), 200'd0);

    // abort coinciding with the final handshake of a 1x1
    abort_matrix(1, 1, 0, 1'b1);
    check("abort_final_drop", data_flow, 200'd0);

    // stray starts during LOAD and HOLD1
    run_matrix(2, 2, 0, -1, 1'b1);

    // reset mid-LOAD
    wr0 = wr_cnt;
    done0 = done_cnt;
    start = 1'b1; cfg_row = 3'd2; cfg_col = 3'd2;
    step();
    start = 1'b0;
    repeat (2) begin
      elem_valid = 1'b1; elem_data = 8'($urandom_range(1, 255));
      step();
    end
    elem_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check_all_zero("async_reset");
    step();
    rst_n = 1'b1;
    exp_flow = '0; exp_row = 3'd0; exp_col = 3'd0;
    repeat (4) step();
    check_all_zero("post_reset");
    check("reset_no_write", 200'(wr_cnt - wr0), 200'd0);
    check("reset_no_done", 200'(done_cnt - done0), 200'd0);

    // randomized matrices
    for (int t = 0; t < 6; t++)
      run_matrix(int'($urandom_range(1, 5)), int'($urandom_range(1, 5)), 2, -1,
                 1'($urandom_range(0, 1)));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
